// File: rtl/int_controller.sv
// Memory-mapped interrupt controller for the jacaranda-8 core: edge-latched pending bits,
// fixed lowest-index priority, one-cycle request pulse, and in-service hold until EOI.
module int_controller #(
    parameter int          N_SRC     = 4,
    parameter logic [7:0]  BASE_ADDR = 8'hF0
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [N_SRC-1:0] src,
    input  logic [7:0]       addr,
    input  logic [7:0]       w_data,
    input  logic             w_en,
    output logic [7:0]       r_data,
    output logic             int_req,
    output logic [7:0]       int_vec,
    output logic [7:0]       int_en
);

    localparam logic [7:0] EN_MASK = 8'((1 << (N_SRC + 1)) - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       en_q, en_d;
    logic [N_SRC-1:0] pend_q, pend_d;
    logic [N_SRC-1:0] src_q, src_d;
    logic [7:0]       vec_q [4];
    logic [7:0]       vec_d [4];
    logic             in_service_q, in_service_d;
    logic [1:0]       id_q, id_d;
    logic             int_req_q, int_req_d;
    logic [7:0]       int_vec_q, int_vec_d;

    logic             hit;
    logic [2:0]       off;
    logic             wr;
    logic [N_SRC-1:0] edges;
    logic [N_SRC-1:0] elig;
    logic [1:0]       sel_id;

    always_comb begin
        hit    = (addr[7:3] == BASE_ADDR[7:3]);
        off    = addr[2:0];
        wr     = w_en && hit;
        edges  = src & ~src_q;
        elig   = pend_q & en_q[N_SRC:1];
        sel_id = 2'd0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (elig[i]) sel_id = 2'(i);
        end

        state_d      = state_q;
        en_d         = en_q;
        pend_d       = pend_q;
        src_d        = src;
        in_service_d = in_service_q;
        id_d         = id_q;
        int_req_d    = 1'b0;
        int_vec_d    = int_vec_q;
        for (int k = 0; k < 4; k++) vec_d[k] = vec_q[k];

        if (wr) begin
            case (off)
                3'd0:    en_d   = w_data & EN_MASK;
                3'd1:    pend_d = pend_q & ~w_data[N_SRC-1:0];
                3'd4, 3'd5, 3'd6, 3'd7: begin
                    if (int'(off[1:0]) < N_SRC) vec_d[off[1:0]] = w_data;
                end
                default: ;
            endcase
        end

        case (state_q)
            IDLE: begin
                if (en_q[0] && (|elig)) begin
                    id_d      = sel_id;
                    int_vec_d = vec_q[sel_id];
                    int_req_d = 1'b1;
                    state_d   = REQ;
                end
            end
            REQ: begin
                // Global enable dropped while leaving IDLE: abort, keep the source pending.
                if (en_q[0]) begin
                    for (int i = 0; i < N_SRC; i++) begin
                        if (2'(i) == id_q) pend_d[i] = 1'b0;
                    end
                    in_service_d = 1'b1;
                    state_d      = SERVICE;
                end else begin
                    state_d = IDLE;
                end
            end
            SERVICE: begin
                if (wr && off == 3'd2) begin
                    in_service_d = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // New edges are applied last so they win over any clear in the same cycle.
        pend_d = pend_d | edges;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            en_q         <= 8'd0;
            pend_q       <= '0;
            src_q        <= '0;
            in_service_q <= 1'b0;
            id_q         <= 2'd0;
            int_req_q    <= 1'b0;
            int_vec_q    <= 8'd0;
            for (int k = 0; k < 4; k++) vec_q[k] <= 8'd0;
        end else begin
            state_q      <= state_d;
            en_q         <= en_d;
            pend_q       <= pend_d;
            src_q        <= src_d;
            in_service_q <= in_service_d;
            id_q         <= id_d;
            int_req_q    <= int_req_d;
            int_vec_q    <= int_vec_d;
            for (int k = 0; k < 4; k++) vec_q[k] <= vec_d[k];
        end
    end

    always_comb begin
        r_data = 8'd0;
        if (hit) begin
            case (off)
                3'd0:    r_data = en_q;
                3'd1:    r_data = 8'(pend_q);
                3'd2:    r_data = {in_service_q, 5'b0, id_q};
                3'd4, 3'd5, 3'd6, 3'd7: begin
                    if (int'(off[1:0]) < N_SRC) r_data = vec_q[off[1:0]];
                end
                default: r_data = 8'd0;
            endcase
        end
    end

    assign int_req = int_req_q;
    assign int_vec = int_vec_q;
    assign int_en  = en_q;

endmodule
